// File: rtl/cnt_carry_scheduler.sv
// -----------------------------------------------------------------------------
// cnt_carry_scheduler
//
// Turns each accepted 1 s tick into a serial carry ripple across the cascaded
// time-field counters (one increment strobe per cycle, seconds first). In
// edit mode it turns a single button press into exactly one increment of the
// selected field, with no carry. It is the only source of counter increment
// strobes.
//
// Ports:
//   clk        in  1         system clock, rising edge
//   rst        in  1         asynchronous active-high reset
//   tick_1s    in  1         one-cycle pulse once per second
//   run_en     in  1         run mode: ticks advance time
//   edit_sel   in  N_FIELDS  one-hot field selected for editing
//   inc_btn    in  1         debounced single-cycle increment request
//   at_max     in  N_FIELDS  bit i high when counter i wraps on next increment
//   inc        out N_FIELDS  registered increment strobes, at most one hot
//   busy       out 1         ripple or edit increment in progress
//   rollover   out 1         one-cycle pulse when the last field wraps
//   tick_lost  out 1         sticky overrun flag, cleared only by rst
// -----------------------------------------------------------------------------
module cnt_carry_scheduler #(
    parameter int N_FIELDS = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_1s,
    input  logic                run_en,
    input  logic [N_FIELDS-1:0] edit_sel,
    input  logic                inc_btn,
    input  logic [N_FIELDS-1:0] at_max,
    output logic [N_FIELDS-1:0] inc,
    output logic                busy,
    output logic                rollover,
    output logic                tick_lost
);

    localparam int                IDX_W    = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_FIELDS - 1);
    localparam logic [N_FIELDS-1:0] FIELD0 = N_FIELDS'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RIPPLE = 2'd1,
        EDIT   = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic                pending_q,   pending_d;
    logic [N_FIELDS-1:0] inc_q,       inc_d;
    logic                busy_q,      busy_d;
    logic                rollover_q,  rollover_d;
    logic                tick_lost_q, tick_lost_d;

    logic                tick_acc_s;
    logic                end_s;
    logic [IDX_W-1:0]    idx_next_s;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [N_FIELDS-1:0] v);
        return (v != '0) && ((v & (v - N_FIELDS'(1))) == '0);
    endfunction

    assign tick_acc_s = tick_1s & run_en;
    assign idx_next_s = idx_q + IDX_W'(1);

    // Next-state and next-output logic; outputs are computed from the next
    // state so the strobes leave the flops in the cycle the state is entered.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pending_d   = pending_q;
        inc_d       = '0;
        rollover_d  = 1'b0;
        tick_lost_d = tick_lost_q;
        end_s       = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick_acc_s) begin
                    state_d = RIPPLE;
                    idx_d   = '0;
                    inc_d   = FIELD0;
                end else if (inc_btn && !run_en && is_onehot(edit_sel)) begin
                    state_d = EDIT;
                    inc_d   = edit_sel;
                end else begin
                    state_d = IDLE;
                end
            end
            RIPPLE: begin
                // at_max is the pre-increment value of the field strobed now
                if (at_max[idx_q] && (idx_q != LAST_IDX)) begin
                    idx_d = idx_next_s;
                    inc_d = FIELD0 << idx_next_s;
                end else begin
                    rollover_d = at_max[idx_q];
                    end_s      = 1'b1;
                end
            end
            EDIT: begin
                end_s = 1'b1;
            end
            default: begin
                state_d   = IDLE;
                idx_d     = '0;
                pending_d = 1'b0;
            end
        endcase

        // A tick while busy is queued once; a second one is discarded.
        if (((state_q == RIPPLE) || (state_q == EDIT)) && tick_acc_s) begin
            if (pending_q) begin
                tick_lost_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end else begin
            tick_lost_d = tick_lost_d;
        end

        // A queued tick (including one arriving in the final cycle) restarts
        // the ripple back-to-back, so there is never an idle gap.
        if (end_s) begin
            if (pending_d) begin
                state_d   = RIPPLE;
                idx_d     = '0;
                inc_d     = FIELD0;
                pending_d = 1'b0;
            end else begin
                state_d = IDLE;
                idx_d   = '0;
            end
        end else begin
            end_s = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            inc_q       <= '0;
            busy_q      <= 1'b0;
            rollover_q  <= 1'b0;
            tick_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            inc_q       <= inc_d;
            busy_q      <= busy_d;
            rollover_q  <= rollover_d;
            tick_lost_q <= tick_lost_d;
        end
    end

    assign inc       = inc_q;
    assign busy      = busy_q;
    assign rollover  = rollover_q;
    assign tick_lost = tick_lost_q;

endmodule

// File: tb/tb_cnt_carry_scheduler.sv
module tb_cnt_carry_scheduler;

    logic       clk;
    logic       rst;
    logic       tick_1s;
    logic       run_en;
    logic [6:0] edit_sel;
    logic       inc_btn;
    logic [6:0] at_max;
    logic [6:0] inc;
    logic       busy;
    logic       rollover;
    logic       tick_lost;

    int n_tests;
    int n_fail;

    cnt_carry_scheduler #(.N_FIELDS(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1s   (tick_1s),
        .run_en    (run_en),
        .edit_sel  (edit_sel),
        .inc_btn   (inc_btn),
        .at_max    (at_max),
        .inc       (inc),
        .busy      (busy),
        .rollover  (rollover),
        .tick_lost (tick_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       tick;
        logic       run;
        logic [6:0] sel;
        logic       btn;
        logic [6:0] amax;
        logic [6:0] e_inc;
        logic       e_busy;
        logic       e_roll;
        logic       e_lost;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(string n, logic t, logic r, logic [6:0] s, logic b,
                                logic [6:0] a, logic [6:0] ei, logic eb, logic er,
                                logic el);
        vec_t v;
        v.name = n; v.tick = t; v.run = r; v.sel = s; v.btn = b; v.amax = a;
        v.e_inc = ei; v.e_busy = eb; v.e_roll = er; v.e_lost = el;
        return v;
    endfunction

    task automatic check(string name, logic [9:0] act, logic [9:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got inc/busy/roll/lost=%b_%b_%b_%b expected %b_%b_%b_%b",
                     name, act[9:3], act[2], act[1], act[0],
                     exp[9:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive one vector, queue its expectation, compare one cycle later.
    task automatic run_vec(vec_t v);
        vec_t e;
        tick_1s  = v.tick;
        run_en   = v.run;
        edit_sel = v.sel;
        inc_btn  = v.btn;
        at_max   = v.amax;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e.name, {inc, busy, rollover, tick_lost},
              {e.e_inc, e.e_busy, e.e_roll, e.e_lost});
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        tick_1s  = 1'b0;
        run_en   = 1'b0;
        edit_sel = 7'd0;
        inc_btn  = 1'b0;
        at_max   = 7'd0;

        // Simple tick
        vecs.push_back(mk("simple_t",   1'b1, 1'b1, 7'd0, 1'b0, 7'h00, 7'h01, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("simple_end", 1'b0, 1'b1, 7'd0, 1'b0, 7'h00, 7'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("simple_idle",1'b0, 1'b1, 7'd0, 1'b0, 7'h00, 7'h00, 1'b0, 1'b0, 1'b0));
        // Partial carry through three fields
        vecs.push_back(mk("part_0", 1'b1, 1'b1, 7'd0, 1'b0, 7'h07, 7'h01, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("part_1", 1'b0, 1'b1, 7'd0, 1'b0, 7'h07, 7'h02, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("part_2", 1'b0, 1'b1, 7'd0, 1'b0, 7'h07, 7'h04, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("part_3", 1'b0, 1'b1, 7'd0, 1'b0, 7'h07, 7'h08, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("part_end",1'b0,1'b1, 7'd0, 1'b0, 7'h07, 7'h00, 1'b0, 1'b0, 1'b0));
        // Full wrap
        vecs.push_back(mk("wrap_0", 1'b1, 1'b1, 7'd0, 1'b0, 7'h7F, 7'h01, 1'b1, 1'b0, 1'b0));
        for (int i = 1; i < 7; i++) begin
            vecs.push_back(mk($sformatf("wrap_%0d", i), 1'b0, 1'b1, 7'd0, 1'b0, 7'h7F,
                              7'(7'h01 << i), 1'b1, 1'b0, 1'b0));
        end
        vecs.push_back(mk("wrap_roll", 1'b0, 1'b1, 7'd0, 1'b0, 7'h7F, 7'h00, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk("wrap_done", 1'b0, 1'b1, 7'd0, 1'b0, 7'h7F, 7'h00, 1'b0, 1'b0, 1'b0));
        // Edit: single increment, no carry; invalid selections ignored
        vecs.push_back(mk("edit_inc",  1'b0, 1'b0, 7'h10, 1'b1, 7'h7F, 7'h10, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("edit_once", 1'b0, 1'b0, 7'h10, 1'b0, 7'h7F, 7'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("edit_multi",1'b0, 1'b0, 7'h14, 1'b1, 7'h7F, 7'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("edit_zero", 1'b0, 1'b0, 7'h00, 1'b1, 7'h7F, 7'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("edit_run",  1'b0, 1'b1, 7'h10, 1'b1, 7'h7F, 7'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("edit_top",  1'b0, 1'b0, 7'h40, 1'b1, 7'h7F, 7'h40, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("edit_top_e",1'b0, 1'b0, 7'h40, 1'b0, 7'h7F, 7'h00, 1'b0, 1'b0, 1'b0));
        // Overrun: three back-to-back ticks during a full wrap
        vecs.push_back(mk("ovr_t1", 1'b1, 1'b1, 7'd0, 1'b0, 7'h7F, 7'h01, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("ovr_t2", 1'b1, 1'b1, 7'd0, 1'b0, 7'h7F, 7'h02, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("ovr_t3", 1'b1, 1'b1, 7'd0, 1'b0, 7'h7F, 7'h04, 1'b1, 1'b0, 1'b1));
        for (int i = 3; i < 7; i++) begin
            vecs.push_back(mk($sformatf("ovr_a%0d", i), 1'b0, 1'b1, 7'd0, 1'b0, 7'h7F,
                              7'(7'h01 << i), 1'b1, 1'b0, 1'b1));
        end
        vecs.push_back(mk("ovr_b0", 1'b0, 1'b1, 7'd0, 1'b0, 7'h7F, 7'h01, 1'b1, 1'b1, 1'b1));
        for (int i = 1; i < 7; i++) begin
            vecs.push_back(mk($sformatf("ovr_b%0d", i), 1'b0, 1'b1, 7'd0, 1'b0, 7'h7F,
                              7'(7'h01 << i), 1'b1, 1'b0, 1'b1));
        end
        vecs.push_back(mk("ovr_roll", 1'b0, 1'b1, 7'd0, 1'b0, 7'h7F, 7'h00, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk("ovr_hold", 1'b0, 1'b1, 7'd0, 1'b0, 7'h7F, 7'h00, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("ovr_hold2",1'b0, 1'b0, 7'd0, 1'b0, 7'h00, 7'h00, 1'b0, 1'b0, 1'b1));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {inc, busy, rollover, tick_lost}, 10'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
        end

        // tick_lost clears only on reset
        rst = 1'b1;
        #1;
        check("lost_cleared", {inc, busy, rollover, tick_lost}, 10'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a ripple, then restart from field 0
        run_en  = 1'b1;
        at_max  = 7'h7F;
        tick_1s = 1'b1;
        @(posedge clk);
        #1;
        tick_1s = 1'b0;
        check("rmid_0", {inc, busy, rollover, tick_lost}, {7'h01, 1'b1, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        check("rmid_1", {inc, busy, rollover, tick_lost}, {7'h02, 1'b1, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        check("rmid_2", {inc, busy, rollover, tick_lost}, {7'h04, 1'b1, 1'b0, 1'b0});
        #3;
        rst = 1'b1;
        #1;
        check("rmid_async", {inc, busy, rollover, tick_lost}, 10'd0);
        #1;
        rst    = 1'b0;
        at_max = 7'h00;
        @(posedge clk);
        #1;
        check("rmid_idle", {inc, busy, rollover, tick_lost}, 10'd0);
        tick_1s = 1'b1;
        @(posedge clk);
        #1;
        tick_1s = 1'b0;
        check("rmid_restart", {inc, busy, rollover, tick_lost}, {7'h01, 1'b1, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        check("rmid_done", {inc, busy, rollover, tick_lost}, 10'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cnt_carry_scheduler.md
# cnt_carry_scheduler

Sequences the seven cascaded time-field counters (second, minute, hour, day, month, year, century) of the century clock. It turns each 1 s tick into a serial, one-field-per-cycle carry ripple of increment strobes. In edit mode it turns single button presses into a single increment of the selected field. It sits between the mode FSM (`enable_cnt`, `enable_pulse_1s`) and the counter datapath, and is the only source of counter increment strobes.

## Interface

- `N_FIELDS`, default 7: number of cascaded fields; field 0 = seconds, field N_FIELDS-1 = century.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `tick_1s`  in  1: one-cycle pulse, once per second.
- `run_en`  in  1: run mode; high means ticks advance time (driven by `enable_pulse_1s`).
- `edit_sel`  in  N_FIELDS: one-hot field selected for editing (driven by `enable_cnt`).
- `inc_btn`  in  1: debounced single-cycle increment request.
- `at_max`  in  N_FIELDS: bit i high when counter i currently holds its maximum value, i.e. the next increment wraps it.
- `inc`  out  N_FIELDS: registered increment strobes, at most one bit high per cycle.
- `busy`  out  1: high while a ripple or edit increment is in progress.
- `rollover`  out  1: one-cycle pulse when the century field wraps.
- `tick_lost`  out  1: sticky overrun flag; cleared only by `rst`.

## Operation

- States: IDLE, RIPPLE (with field index `idx`, 0..N_FIELDS-1), EDIT.
- Reset (async): state IDLE, `idx`=0, pending=0, and `inc`, `busy`, `rollover`, `tick_lost` all 0.
- IDLE:
  - If `tick_1s` and `run_en` are both high, go to RIPPLE with `idx`=0.
  - Otherwise, if `inc_btn` is high, `run_en` is low and `edit_sel` is exactly one-hot, go to EDIT.
  - `inc_btn` with `edit_sel` zero or multi-hot is ignored.
- RIPPLE:
  - `inc[idx]`=1 this cycle.
  - If `at_max[idx]`=1 (sampled in the same cycle as the strobe, i.e. the pre-increment value) and `idx`<N_FIELDS-1, then `idx`←`idx`+1 and stay in RIPPLE.
  - If `at_max[idx]`=1 and `idx`=N_FIELDS-1, pulse `rollover` next cycle and end the ripple.
  - If `at_max[idx]`=0, end the ripple.
  - End of ripple: if pending=1, clear pending and restart RIPPLE at `idx`=0 on the next cycle; otherwise return to IDLE.
- EDIT: `inc[k]`=1 for the selected k, for one cycle only. There is no carry, whatever `at_max` says. Then return to IDLE.
- Tick during RIPPLE or EDIT with `run_en`=1:
  - If pending=0, set pending.
  - If pending=1, set `tick_lost`; that tick is discarded.
- `inc_btn` while not IDLE is dropped; nothing is queued.
- Deasserting `run_en` mid-ripple does not abort the ripple; it completes. A pending tick still launches after it.
- Changing `edit_sel` during EDIT has no effect; the field is latched on the IDLE→EDIT transition.
- `rst` mid-ripple: `inc` goes to 0 immediately (async) and the partial carry is abandoned.

## Timing

- Tick accepted in cycle t → `inc[0]` in t+1, `inc[k]` in t+1+k while the carry propagates.
- Worst case is a full wrap: `inc[N_FIELDS-1]` in t+N_FIELDS, then `rollover` in t+N_FIELDS+1.
- `busy`=1 exactly in the cycles where `inc` is nonzero or a pending restart is queued.
- Pending restart: the ripple ending in cycle c gives `inc[0]` in c+1. There is no idle gap.
- `inc_btn` in cycle t (IDLE) → `inc[sel]` in t+1, `busy` high in t+1 only.
- `tick_lost` rises the cycle after the discarded tick and stays high until reset.
- All outputs come straight from flops; there is no combinational path from input to output.

## Test plan

- **Simple tick:** reset, `run_en`=1, `at_max`=0, tick at cycle 10 → `inc`=0000001 in cycle 11 only; `busy` high in cycle 11 only.
- **Partial carry:** `at_max`=0000111, tick at cycle 10 → `inc` goes 0000001, 0000010, 0000100, 0001000 in cycles 11–14; `rollover` stays 0.
- **Full wrap:** `at_max`=1111111, tick → `inc` walks bits 0..6 over 7 cycles; `rollover` pulses once, in the cycle after `inc[6]`.
- **Edit:**
  - `run_en`=0, `edit_sel`=0010000, `at_max`=1111111, `inc_btn` pulse → `inc`=0010000 for one cycle, no carry.
  - Same stimulus with `edit_sel`=0010100 → `inc` stays 0.
- **Overrun:** `at_max`=1111111, three ticks on consecutive cycles → first ripple, then an immediate second ripple; `tick_lost`=1 from the cycle after the third tick, held until `rst`.
- **Reset mid-ripple:** assert `rst` while `inc`=0000100 → `inc`, `busy`, pending and `idx` clear asynchronously; after release, a tick gives `inc`=0000001 one cycle later.
